qmax_update: RTL

Read-compare-write stage that sits directly in front of the qmax BRAM table. It accepts (state, candidate Q) pairs from the Q-value compute pipeline and issues the table read. It compares the returned stored maximum against the candidate and writes back only when the candidate is strictly larger, forwarding in-flight results so back-to-back updates to the same state are exact. After reset, and on request, it also initialises every table entry, because the table itself has no reset.

---
 rtl/qmax_pkg.sv | 12 +
 rtl/qmax_fwd.sv | 22 ++
 rtl/qmax_update.sv | 93 +++++++++
 3 files changed

// File: rtl/qmax_pkg.sv
// qmax_pkg: shared FSM state, stage record and default widths for the qmax update stage
package qmax_pkg;
   localparam int ADDR_W  = 6;
   localparam int DATA_W  = 32;
   localparam int DEPTH_D = 64;
   typedef enum logic [1:0] {INIT, RUN, DRAIN} st_t;
   typedef struct packed {
      logic                     valid;
      logic [ADDR_W-1:0]        addr;
      logic signed [DATA_W-1:0] value;
   } stage_t;
endpackage

// File: rtl/qmax_fwd.sv
// qmax_fwd: picks the freshest stored max for the compare address and decides on a write
module qmax_fwd
   import qmax_pkg::*;
(
   input  logic                     valid,
   input  logic [ADDR_W-1:0]        addr,
   input  logic signed [DATA_W-1:0] q,
   input  stage_t                   s2,
   input  stage_t                   s3,
   input  logic signed [DATA_W-1:0] tbl_data,
   output logic signed [DATA_W-1:0] max,
   output logic                     do_write
);
   logic signed [DATA_W-1:0] old;
   // newest in-flight result wins over older one, memory data only when nothing in flight matches
   always_comb begin
      old      = (s2.valid && s2.addr == addr) ? s2.value :
                 (s3.valid && s3.addr == addr) ? s3.value : tbl_data;
      do_write = valid && (q > old);
      max      = (q > old) ? q : old;
   end
endmodule

// File: rtl/qmax_update.sv
// qmax_update: read-compare-write front end of the qmax table with init sweep; QMAX_UPD_STATS_EN adds the improving-write counter
module qmax_update
   import qmax_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_W,
   parameter int DATA_WIDTH = DATA_W,
   parameter int DEPTH      = DEPTH_D,
   parameter logic signed [DATA_WIDTH-1:0] INIT_VAL = '0
)(
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic [ADDR_WIDTH-1:0]        i_state,
   input  logic signed [DATA_WIDTH-1:0] i_q,
   input  logic                         i_clear,
   output logic                         o_rd_en,
   output logic [ADDR_WIDTH-1:0]        o_rd_addr,
   input  logic signed [DATA_WIDTH-1:0] i_tbl_data,
   output logic                         o_wr_en,
   output logic [ADDR_WIDTH-1:0]        o_wr_addr,
   output logic signed [DATA_WIDTH-1:0] o_wr_data,
   output logic                         o_init_done,
   output logic [31:0]                  o_upd_cnt
);
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   st_t state, nxt;
   logic [ADDR_WIDTH:0] cnt;
   stage_t s1, s2, s3;
   logic signed [DATA_WIDTH-1:0] max;
   logic do_write, acc;
   assign acc       = i_valid & o_ready;
   assign o_rd_en   = acc;
   assign o_rd_addr = i_state;
   qmax_fwd u_fwd (
      .valid(s1.valid), .addr(s1.addr), .q(s1.value), .s2(s2), .s3(s3),
      .tbl_data(i_tbl_data), .max(max), .do_write(do_write)
   );
   // sweep until the counter reaches DEPTH, leave DRAIN once no compare is pending
   always_comb begin
      nxt = state;
      if (state == INIT) nxt = (!i_clear && cnt == DEPTH_C) ? RUN : INIT;
      else if (state == RUN) nxt = i_clear ? DRAIN : RUN;
      else nxt = s1.valid ? DRAIN : INIT;
   end
   // state register, sweep counter and handshake flags
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= INIT;
         cnt         <= '0;
         o_ready     <= 1'b0;
         o_init_done <= 1'b0;
      end else begin
         state       <= nxt;
         cnt         <= (state != INIT || i_clear) ? '0 : (cnt != DEPTH_C) ? cnt + 1'b1 : cnt;
         o_ready     <= nxt == RUN;
         o_init_done <= nxt == RUN;
      end
   end
   // pipeline stages; in-flight forwarding state is dropped whenever a sweep is running
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= '{acc, i_state, i_q};
         s2 <= '{s1.valid && nxt != INIT, s1.addr, max};
         s3 <= '{s2.valid && nxt != INIT, s2.addr, s2.value};
      end
   end
   // registered write port: sweep writes during INIT, improving candidates otherwise
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_wr_en   <= 1'b0;
         o_wr_addr <= '0;
         o_wr_data <= '0;
      end else begin
         o_wr_en   <= (state == INIT) ? (!i_clear && cnt != DEPTH_C) : do_write;
         o_wr_addr <= (state == INIT) ? cnt[ADDR_WIDTH-1:0] : s1.addr;
         o_wr_data <= (state == INIT) ? INIT_VAL : s1.value;
      end
   end
`ifdef QMAX_UPD_STATS_EN
   // saturating count of improving writes, restarted with every sweep
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) o_upd_cnt <= '0;
      else o_upd_cnt <= (nxt == INIT) ? '0 : (do_write && o_upd_cnt != '1) ? o_upd_cnt + 32'd1 : o_upd_cnt;
   end
`else
   assign o_upd_cnt = '0;
`endif
endmodule
